// File: rtl/lane_mul_sequencer.sv
// ---------------------------------------------------------------------------
// lane_mul_sequencer
//
// Time-multiplexed lane scaler. Holds N lanes of W bits. Every accepted input
// word is shifted into lane 0 (lane N-1 falls off the end), then a sweep walks
// the lanes 0..N-1, one per cycle, replacing each lane with lane*K through a
// single shared multiplier. When the sweep is done, lane N-1 is offered
// downstream on a valid/ready handshake.
//
// Optional feature (compile-time macro):
//   LANE_SEQ_SAT_EN  defined   -> a product >= 2^W saturates the lane to all-ones
//                    undefined -> the product wraps modulo 2^W
//
// Parameters:
//   W  lane / data width in bits
//   N  number of lanes (>= 2)
//   K  constant multiplier operand (unsigned, W bits)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   in_data    input word
//   in_valid   input word is valid
//   in_ready   block can take an input word (only while idle)
//   out_data   lane N-1 after a completed sweep
//   out_valid  out_data is valid
//   out_ready  downstream takes out_data
//   busy       a sweep is running or a result is waiting
// ---------------------------------------------------------------------------
module lane_mul_sequencer #(
   parameter int unsigned W = 100,
   parameter int unsigned N = 10,
   parameter logic [W-1:0] K = W'(2)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy
);

   localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      OUT   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] laneIdx_q, laneIdx_d;
   logic [W-1:0]    lanes_q [N];
   logic [W-1:0]    lanes_d [N];

   logic [W-1:0]    mulOperand;
   logic [W-1:0]    scaledLane;

   // The one shared multiplier: its operand mux picks the lane the sweep
   // counter is pointing at.
   assign mulOperand = lanes_q[laneIdx_q];

`ifdef LANE_SEQ_SAT_EN
   // Full double-width product so any overflow above bit W-1 is visible and
   // can clamp the lane to all-ones.
   logic [2*W-1:0] mulProduct;
   assign mulProduct = {{W{1'b0}}, mulOperand} * {{W{1'b0}}, K};
   assign scaledLane = (|mulProduct[2*W-1:W]) ? {W{1'b1}} : mulProduct[W-1:0];
`else
   // Wrap-around: only the low W bits of the product are kept, so a W-bit
   // product is all that is needed.
   logic [W-1:0] mulProduct;
   assign mulProduct = mulOperand * K;
   assign scaledLane = mulProduct;
`endif

   // State, sweep counter and lane storage. Reset clears everything, which
   // also throws away a sweep in progress or a result still waiting to leave.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         laneIdx_q <= '0;
         for (int i = 0; i < N; i++) begin
            lanes_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         laneIdx_q <= laneIdx_d;
         for (int i = 0; i < N; i++) begin
            lanes_q[i] <= lanes_d[i];
         end
      end
   end

   // Next-state logic. IDLE shifts a new word in and arms the sweep, SWEEP
   // scales one lane per cycle in ascending order, OUT holds everything
   // still until the result is taken.
   always_comb begin
      state_d   = state_q;
      laneIdx_d = laneIdx_q;
      for (int i = 0; i < N; i++) begin
         lanes_d[i] = lanes_q[i];
      end

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               for (int i = 1; i < N; i++) begin
                  lanes_d[i] = lanes_q[i-1];
               end
               lanes_d[0] = in_data;
               laneIdx_d  = '0;
               state_d    = SWEEP;
            end
         end

         SWEEP: begin
            lanes_d[laneIdx_q] = scaledLane;
            if (laneIdx_q == LAST_IDX) begin
               state_d = OUT;
            end else begin
               laneIdx_d = laneIdx_q + IDXW'(1);
            end
         end

         OUT: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake outputs come straight from the state, so in_ready and
   // out_valid can never be high together.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == OUT);
   assign busy      = (state_q == SWEEP) || (state_q == OUT);
   assign out_data  = lanes_q[N-1];

endmodule

// File: tb/tb_lane_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lane_mul_sequencer
//
// Directed bench for lane_mul_sequencer. A small instance (W=8, N=4, K=2)
// covers reset, latency, lane shifting, overflow and back-pressure; a second
// instance with the default parameters (W=100, N=10, K=2) covers the full
// size. Expected values are worked out by hand in the stimulus below.
// ---------------------------------------------------------------------------
module tb_lane_mul_sequencer;

   logic        clk;
   logic        rst;

   logic [7:0]  inData;
   logic        inValid;
   logic        inReady;
   logic [7:0]  outData;
   logic        outValid;
   logic        outReady;
   logic        busy;

   logic [99:0] bigInData;
   logic        bigInValid;
   logic        bigInReady;
   logic [99:0] bigOutData;
   logic        bigOutValid;
   logic        bigOutReady;
   logic        bigBusy;

   int compared;
   int mismatched;

   lane_mul_sequencer #(.W(8), .N(4), .K(8'd2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (inData),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .out_data  (outData),
      .out_valid (outValid),
      .out_ready (outReady),
      .busy      (busy)
   );

   lane_mul_sequencer bigDut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (bigInData),
      .in_valid  (bigInValid),
      .in_ready  (bigInReady),
      .out_data  (bigOutData),
      .out_valid (bigOutValid),
      .out_ready (bigOutReady),
      .busy      (bigBusy)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle 1 ns past it, so every check samples
   // away from the edge and every drive lands well before the next one.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Push one word into the small instance, wait (bounded) for its result,
   // check it and consume it.
   task automatic applyStimulus(input logic [7:0] data, input logic [7:0] expOut,
                                input string tag);
      inData  = data;
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
      for (int c = 0; c < 20 && !outValid; c++) begin
         tick();
      end
      checkOutput({tag, "_valid"}, 128'(outValid), 128'd1);
      checkOutput({tag, "_data"}, 128'(outData), 128'(expOut));
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
   endtask

   // Same as applyStimulus, for the full-size instance.
   task automatic applyBigStimulus(input logic [99:0] data, input logic [99:0] expOut,
                                   input string tag);
      bigInData  = data;
      bigInValid = 1'b1;
      tick();
      bigInValid = 1'b0;
      for (int c = 0; c < 40 && !bigOutValid; c++) begin
         tick();
      end
      checkOutput({tag, "_valid"}, 128'(bigOutValid), 128'd1);
      checkOutput({tag, "_data"}, 128'(bigOutData), 128'(expOut));
      bigOutReady = 1'b1;
      tick();
      bigOutReady = 1'b0;
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // Directed stimulus, one step after another.
   initial begin
      logic [7:0] satExpect;
      compared    = 0;
      mismatched  = 0;
      inData      = '0;
      inValid     = 1'b0;
      outReady    = 1'b0;
      bigInData   = '0;
      bigInValid  = 1'b0;
      bigOutReady = 1'b0;
      rst         = 1'b1;
      #1;
      tick();
      tick();

      // Values while reset is held, then just after release.
      checkOutput("rst_in_ready", 128'(inReady), 128'd1);
      checkOutput("rst_out_valid", 128'(outValid), 128'd0);
      checkOutput("rst_busy", 128'(busy), 128'd0);
      checkOutput("rst_out_data", 128'(outData), 128'h00);
      rst = 1'b0;
      tick();
      checkOutput("idle_in_ready", 128'(inReady), 128'd1);

      // Start a sweep with 0x55 and reset it halfway through.
      inData  = 8'h55;
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
      checkOutput("sweep_busy", 128'(busy), 128'd1);
      checkOutput("sweep_in_ready", 128'(inReady), 128'd0);
      tick();
      rst = 1'b1;
      tick();
      checkOutput("midrst_in_ready", 128'(inReady), 128'd1);
      checkOutput("midrst_out_valid", 128'(outValid), 128'd0);
      checkOutput("midrst_busy", 128'(busy), 128'd0);
      checkOutput("midrst_out_data", 128'(outData), 128'h00);
      rst = 1'b0;
      tick();

      // Four words from cleared lanes: {0,0,0,0} -> lanes {16,16,12,8}.
      // Any leftover 0x55 would surface in the third or fourth output.
      applyStimulus(8'h01, 8'h00, "seq_out1");
      applyStimulus(8'h02, 8'h00, "seq_out2");
      applyStimulus(8'h03, 8'h00, "seq_out3");
      applyStimulus(8'h04, 8'h10, "seq_out4");

      // Latency: in_valid in cycle 0, out_valid first seen in cycle 5.
      pulseReset();
      inData  = 8'h03;
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         checkOutput($sformatf("lat_wait%0d", k), 128'(outValid), 128'd0);
         tick();
      end
      checkOutput("lat_wait4", 128'(outValid), 128'd0);
      tick();
      checkOutput("lat_valid", 128'(outValid), 128'd1);
      checkOutput("lat_data", 128'(outData), 128'h00);
      checkOutput("lat_in_ready", 128'(inReady), 128'd0);
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      checkOutput("lat_back_idle", 128'(inReady), 128'd1);
      // lane0 holds 0x06; it reaches lane3 after three more words.
      applyStimulus(8'h00, 8'h00, "lat_follow1");
      applyStimulus(8'h00, 8'h00, "lat_follow2");
      applyStimulus(8'h00, 8'h30, "lat_follow3");

      // Overflow: 0x90 -> 0x20 -> 0x40 -> 0x80 -> 0x00 wrapping,
      // or stuck at 0xFF with saturation.
`ifdef LANE_SEQ_SAT_EN
      satExpect = 8'hFF;
`else
      satExpect = 8'h00;
`endif
      pulseReset();
      applyStimulus(8'h90, 8'h00, "ovf_out1");
      applyStimulus(8'h00, 8'h00, "ovf_out2");
      applyStimulus(8'h00, 8'h00, "ovf_out3");
      applyStimulus(8'h00, satExpect, "ovf_out4");

      // Back-pressure: fill to lanes {8,12,16,16}, then hold out_ready low
      // for ten cycles while poking in_valid with 0xFF.
      pulseReset();
      applyStimulus(8'h01, 8'h00, "hold_pre1");
      applyStimulus(8'h02, 8'h00, "hold_pre2");
      applyStimulus(8'h03, 8'h00, "hold_pre3");
      inData  = 8'h04;
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
      for (int c = 0; c < 20 && !outValid; c++) begin
         tick();
      end
      inData = 8'hFF;
      for (int c = 0; c < 10; c++) begin
         inValid = c[0];
         tick();
         checkOutput($sformatf("hold_valid%0d", c), 128'(outValid), 128'd1);
         checkOutput($sformatf("hold_data%0d", c), 128'(outData), 128'h10);
         checkOutput($sformatf("hold_in_ready%0d", c), 128'(inReady), 128'd0);
      end
      inValid  = 1'b0;
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      checkOutput("release_in_ready", 128'(inReady), 128'd1);
      checkOutput("release_out_valid", 128'(outValid), 128'd0);
      checkOutput("release_busy", 128'(busy), 128'd0);
      // {8,12,16,16} + 0x00 -> {0,16,24,32}: lanes untouched by the pokes.
      applyStimulus(8'h00, 8'h20, "release_next");

      // Full-size instance: ten 1s, the first one doubled ten times.
      pulseReset();
      for (int n = 1; n <= 9; n++) begin
         applyBigStimulus(100'd1, 100'd0, $sformatf("big_out%0d", n));
      end
      applyBigStimulus(100'd1, 100'd1024, "big_out10");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
